// File: rtl/mem_fabric_pkg.sv
// rtl/mem_fabric_pkg.sv - shared types and constants for the CPU-to-RAM/MMIO fabric
package mem_fabric_pkg;

  typedef enum logic [1:0] {IDLE, RAM_RD, IO_RD, IO_WR} fsm_t;
  typedef enum logic [1:0] {REG_RAM, REG_IO, REG_UNMAPPED} region_t;

  localparam logic [31:0] RD_ERR_IO    = 32'hFFFF_FFFF;
  localparam logic [31:0] RD_ERR_UNMAP = 32'h0000_0000;

  // A single bank needs no bank-select bits at all.
  function automatic int bank_bits(input int n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

endpackage

// File: rtl/mem_addr_decode.sv
// rtl/mem_addr_decode.sv - splits a CPU byte address into region, bank and word
module mem_addr_decode
  import mem_fabric_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int BANK_AW   = 10,
  parameter int MMIO_BIT  = 22,
  localparam int BW       = bank_bits(NUM_BANKS),
  localparam int BIW      = (BW > 0) ? BW : 1
) (
  input  logic [31:0]        addr,
  output region_t            region,
  output logic [BIW-1:0]     bank,
  output logic [BANK_AW-1:0] word
);

  localparam int          LO      = BANK_AW + 2 + BW;
  localparam logic [31:0] HI_MASK = ~((32'd1 << LO) - 32'd1) & ~(32'd1 << MMIO_BIT);

  assign word = addr[BANK_AW+1:2];

  if (BW > 0) begin : g_bank
    assign bank = addr[BANK_AW+2 +: BW];
  end else begin : g_nobank
    assign bank = '0;
  end

  always_comb begin
    region = REG_RAM;
    if (addr[MMIO_BIT])          region = REG_IO;
    else if (|(addr & HI_MASK))  region = REG_UNMAPPED;
  end

endmodule

// File: rtl/mem_bank_fabric.sv
// rtl/mem_bank_fabric.sv - FemtoRV native bus to banked sync RAM plus one MMIO port
module mem_bank_fabric
  import mem_fabric_pkg::*;
#(
  parameter int NUM_BANKS  = 2,
  parameter int BANK_AW    = 10,
  parameter int RD_LAT     = 1,
  parameter int MMIO_BIT   = 22,
  parameter int IO_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic [31:0]             cpu_addr,
  input  logic [31:0]             cpu_wdata,
  input  logic [3:0]              cpu_wmask,
  input  logic                    cpu_rstrb,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_rbusy,
  output logic                    cpu_wbusy,
  output logic [BANK_AW-1:0]      ram_addr,
  output logic [31:0]             ram_wdata,
  output logic [3:0]              ram_byteena,
  output logic [NUM_BANKS-1:0]    ram_wren,
  output logic [NUM_BANKS-1:0]    ram_rden,
  input  logic [NUM_BANKS*32-1:0] ram_rdata,
  output logic                    io_req,
  output logic                    io_we,
  output logic [31:0]             io_addr,
  output logic [31:0]             io_wdata,
  output logic [3:0]              io_wmask,
  input  logic                    io_ack,
  input  logic [31:0]             io_rdata,
  input  logic                    err_clr,
  output logic                    err_flag
);

  localparam int          BW  = bank_bits(NUM_BANKS);
  localparam int          BIW = (BW > 0) ? BW : 1;
  localparam logic [1:0]  LAT = 2'(RD_LAT);
  localparam logic [15:0] TMO = 16'(IO_TIMEOUT);

  region_t              region;
  logic [BIW-1:0]       bank, bank_q;
  logic [BANK_AW-1:0]   word;
  fsm_t                 state, state_nx;
  logic [1:0]           lat_cnt;
  logic [15:0]          tmo_cnt;
  logic                 unmap_q, err_set;
  logic                 wr, rd, strobe, idle, io_busy, io_abort;
  logic [NUM_BANKS-1:0] bank_sel;

  mem_addr_decode #(.NUM_BANKS(NUM_BANKS), .BANK_AW(BANK_AW), .MMIO_BIT(MMIO_BIT)) u_decode (
    .addr   (cpu_addr),
    .region (region),
    .bank   (bank),
    .word   (word)
  );

  assign wr       = |cpu_wmask;
  assign rd       = cpu_rstrb & ~wr;
  assign strobe   = cpu_rstrb | wr;
  assign idle     = (state == IDLE);
  assign io_busy  = (state == IO_RD) || (state == IO_WR);
  assign io_abort = io_busy && !io_ack && (tmo_cnt == TMO);
  assign bank_sel = NUM_BANKS'(1) << bank;

  // RAM side is pass-through; gated by reset so nothing toggles the banks while held.
  assign ram_addr    = rstN ? word : '0;
  assign ram_wdata   = rstN ? cpu_wdata : '0;
  assign ram_byteena = rstN ? cpu_wmask : '0;
  assign ram_wren    = (rstN && idle && wr && region == REG_RAM) ? bank_sel : '0;
  assign ram_rden    = (rstN && idle && rd && region == REG_RAM) ? bank_sel : '0;

  assign cpu_rbusy = (state == RAM_RD) || (state == IO_RD);
  assign cpu_wbusy = (state == IO_WR);

  always_comb begin
    state_nx = state;
    err_set  = 1'b0;
    case (state)
      IDLE: if (strobe) begin
        err_set = (cpu_rstrb && wr) || (region == REG_UNMAPPED);
        if (region == REG_IO) state_nx = wr ? IO_WR : IO_RD;
        else if (rd)          state_nx = RAM_RD;
      end
      RAM_RD:       if (lat_cnt == LAT) state_nx = IDLE;
      IO_RD, IO_WR: if (io_ack || io_abort) state_nx = IDLE;
      default:      state_nx = IDLE;
    endcase
    if ((!idle && strobe) || io_abort) err_set = 1'b1;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      bank_q    <= '0;
      unmap_q   <= 1'b0;
      lat_cnt   <= '0;
      tmo_cnt   <= '0;
      cpu_rdata <= '0;
      err_flag  <= 1'b0;
      io_req    <= 1'b0;
      io_we     <= 1'b0;
      io_addr   <= '0;
      io_wdata  <= '0;
      io_wmask  <= '0;
    end else begin
      state    <= state_nx;
      err_flag <= err_set | (err_flag & ~err_clr);
      case (state)
        IDLE: if (strobe) begin
          bank_q  <= bank;
          unmap_q <= (region == REG_UNMAPPED);
          // Unmapped reads reuse RAM_RD but finish after a single busy cycle.
          lat_cnt <= (region == REG_UNMAPPED) ? LAT : 2'd1;
          tmo_cnt <= 16'd1;
          if (region == REG_IO) begin
            io_req   <= 1'b1;
            io_we    <= wr;
            io_addr  <= cpu_addr;
            io_wdata <= cpu_wdata;
            io_wmask <= cpu_wmask;
          end
        end
        RAM_RD: begin
          if (lat_cnt == LAT)
            cpu_rdata <= unmap_q ? RD_ERR_UNMAP : ram_rdata[32*bank_q +: 32];
          else
            lat_cnt <= lat_cnt + 2'd1;
        end
        IO_RD, IO_WR: begin
          if (io_ack) begin
            io_req <= 1'b0;
            if (state == IO_RD) cpu_rdata <= io_rdata;
          end else if (io_abort) begin
            io_req    <= 1'b0;
            cpu_rdata <= RD_ERR_IO;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bank_fabric.sv
// tb/tb_mem_bank_fabric.sv - scoreboard bench for mem_bank_fabric with RAM and MMIO models
module tb_mem_bank_fabric;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [3:0]  cpu_wmask = '0;
  logic        cpu_rstrb = 1'b0;
  logic [31:0] cpu_rdata;
  logic        cpu_rbusy, cpu_wbusy;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_byteena;
  logic [1:0]  ram_wren, ram_rden;
  logic [63:0] ram_rdata;
  logic        io_req, io_we;
  logic [31:0] io_addr, io_wdata;
  logic [3:0]  io_wmask;
  logic        io_ack = 1'b0;
  logic [31:0] io_rdata = '0;
  logic        err_clr = 1'b0;
  logic        err_flag;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] shadow [logic [31:0]];

  always #5 clk = ~clk;

  mem_bank_fabric #(.NUM_BANKS(2), .BANK_AW(10), .RD_LAT(2), .MMIO_BIT(22), .IO_TIMEOUT(8)) dut (
    .clk(clk), .rstN(rstN),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask), .cpu_rstrb(cpu_rstrb),
    .cpu_rdata(cpu_rdata), .cpu_rbusy(cpu_rbusy), .cpu_wbusy(cpu_wbusy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_byteena(ram_byteena),
    .ram_wren(ram_wren), .ram_rden(ram_rden), .ram_rdata(ram_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata), .io_wmask(io_wmask),
    .io_ack(io_ack), .io_rdata(io_rdata), .err_clr(err_clr), .err_flag(err_flag)
  );

  // Two-stage synchronous RAM per bank: q is valid two cycles after rden.
  logic [31:0] mem [2][1024];
  logic [31:0] p1 [2];
  logic [31:0] p2 [2];
  initial begin
    for (int b = 0; b < 2; b++) begin
      p1[b] = '0;
      p2[b] = '0;
      for (int w = 0; w < 1024; w++) mem[b][w] = '0;
    end
  end
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (ram_wren[b])
        for (int i = 0; i < 4; i++)
          if (ram_byteena[i]) mem[b][ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      if (ram_rden[b]) p1[b] <= mem[b][ram_addr];
      p2[b] <= p1[b];
    end
  end
  assign ram_rdata = {p2[1], p2[0]};

  // MMIO responder: acks ack_delay cycles after io_req is first seen.
  logic        ack_en = 1'b0;
  int          ack_delay = 5;
  logic [31:0] ack_data = '0;
  int          req_cnt = 0;
  always @(negedge clk) begin
    io_ack = 1'b0;
    if (io_req && ack_en) begin
      req_cnt++;
      if (req_cnt == ack_delay + 1) begin
        io_ack   = 1'b1;
        io_rdata = ack_data;
      end
    end else begin
      req_cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] shadow_rd(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    return shadow.exists(k) ? shadow[k] : 32'h0;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_rbusy"}, 32'(cpu_rbusy), 32'h0);
    check({tag, "_wbusy"}, 32'(cpu_wbusy), 32'h0);
    check({tag, "_rdata"}, cpu_rdata, 32'h0);
    check({tag, "_err"}, 32'(err_flag), 32'h0);
    check({tag, "_io"}, {27'(io_req), io_wmask, io_we}, 32'h0);
    check({tag, "_ioaddr"}, io_addr | io_wdata, 32'h0);
    check({tag, "_ram"}, {18'h0, ram_addr, ram_wren, ram_rden}, 32'h0);
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                           input logic [1:0] exp_wren, input logic [9:0] exp_addr, input string tag);
    logic [31:0] k;
    @(negedge clk);
    cpu_addr = a; cpu_wdata = d; cpu_wmask = m;
    #1;
    check({tag, "_wren"}, 32'(ram_wren), 32'(exp_wren));
    check({tag, "_addr_be"}, {18'h0, ram_addr, ram_byteena}, {18'h0, exp_addr, m});
    check({tag, "_wbusy"}, 32'(cpu_wbusy), 32'h0);
    if (exp_wren != 2'b00) begin
      k = {a[31:2], 2'b00};
      shadow[k] = shadow_rd(a);
      for (int i = 0; i < 4; i++) if (m[i]) shadow[k][8*i +: 8] = d[8*i +: 8];
    end
    @(negedge clk);
    cpu_wmask = '0; cpu_rstrb = 1'b0;
  endtask

  task automatic cpu_read(input logic [31:0] a, input logic [31:0] exp, input int exp_busy,
                          input logic [1:0] exp_rden, input string tag);
    int busy;
    @(negedge clk);
    cpu_addr = a; cpu_rstrb = 1'b1;
    exp_q.push_back(exp);
    #1;
    check({tag, "_rden"}, 32'(ram_rden), 32'(exp_rden));
    @(negedge clk);
    cpu_rstrb = 1'b0;
    busy = 0;
    while (cpu_rbusy && busy < 100) begin
      busy++;
      @(negedge clk);
    end
    check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    check({tag, "_rdata"}, cpu_rdata, exp_q.pop_front());
  endtask

  task automatic clear_err();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    check("err_clear", 32'(err_flag), 32'h0);
  endtask

  initial begin
    int busy;
    cpu_wmask = 4'hF; cpu_rstrb = 1'b1; cpu_addr = 32'h1000;
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset");
    cpu_wmask = '0; cpu_rstrb = 1'b0;
    @(negedge clk); rstN = 1'b1;

    cpu_write(32'h0000_1000, 32'hCAFE_0001, 4'hF, 2'b10, 10'd0, "wr_b1");
    cpu_read (32'h0000_1000, 32'hCAFE_0001, 2, 2'b10, "rd_b1");
    cpu_write(32'h0000_0008, 32'h00AB_0000, 4'b0100, 2'b01, 10'd2, "wr_byte");
    cpu_read (32'h0000_0008, shadow_rd(32'h0000_0008), 2, 2'b01, "rd_byte");
    cpu_write(32'h0000_1004, 32'h5555_AAAA, 4'b0011, 2'b10, 10'd1, "wr_half");
    cpu_read (32'h0000_1004, shadow_rd(32'h0000_1004), 2, 2'b10, "rd_half");
    check("no_err_ram", 32'(err_flag), 32'h0);

    ack_en = 1'b1; ack_delay = 5; ack_data = 32'h0000_1234;
    cpu_read(32'h0040_0010, 32'h0000_1234, 6, 2'b00, "io_rd");
    check("io_rd_addr", io_addr, 32'h0040_0010);
    check("io_rd_we", 32'(io_we), 32'h0);
    check("io_rd_err", 32'(err_flag), 32'h0);

    ack_en = 1'b0;
    cpu_write(32'h0040_0020, 32'h0BAD_F00D, 4'b1010, 2'b00, 10'd8, "io_wr");
    busy = 0;
    while (cpu_wbusy && busy < 100) begin
      busy++;
      @(negedge clk);
    end
    check("io_wr_tmo_busy", 32'(busy), 32'd8);
    check("io_wr_fields", io_wdata, 32'h0BAD_F00D);
    check("io_wr_mask_we", {27'(io_req), io_wmask, io_we}, {27'h0, 4'b1010, 1'b1});
    check("io_wr_abort_rdata", cpu_rdata, 32'hFFFF_FFFF);
    check("io_wr_err", 32'(err_flag), 32'h1);
    clear_err();

    cpu_read(32'h8000_0000, 32'h0, 1, 2'b00, "unmap_rd");
    check("unmap_err", 32'(err_flag), 32'h1);
    clear_err();

    @(negedge clk);
    cpu_addr = 32'h0000_0010; cpu_wdata = 32'h0000_0077; cpu_wmask = 4'hF; cpu_rstrb = 1'b1;
    shadow[32'h0000_0010] = 32'h0000_0077;
    #1;
    check("both_wren", 32'(ram_wren), 32'h1);
    check("both_rden", 32'(ram_rden), 32'h0);
    @(negedge clk);
    cpu_wmask = '0; cpu_rstrb = 1'b0;
    check("both_rbusy", 32'(cpu_rbusy), 32'h0);
    check("both_err", 32'(err_flag), 32'h1);
    clear_err();

    @(negedge clk);
    cpu_addr = 32'h8000_0004; cpu_wdata = 32'h1; cpu_wmask = 4'hF; err_clr = 1'b1;
    #1 check("unmap_wr_wren", 32'(ram_wren), 32'h0);
    @(negedge clk);
    cpu_wmask = '0; err_clr = 1'b0;
    check("err_set_over_clr", 32'(err_flag), 32'h1);
    clear_err();

    @(negedge clk);
    cpu_addr = 32'h0000_1000; cpu_rstrb = 1'b1;
    @(negedge clk);
    cpu_rstrb = 1'b1;
    check("busy_strobe_rbusy", 32'(cpu_rbusy), 32'h1);
    @(negedge clk);
    cpu_rstrb = 1'b0;
    check("busy_strobe_err", 32'(err_flag), 32'h1);
    repeat (3) @(negedge clk);
    check("busy_strobe_rdata", cpu_rdata, 32'hCAFE_0001);
    clear_err();

    @(negedge clk);
    cpu_addr = 32'h0000_1000; cpu_rstrb = 1'b1;
    @(negedge clk);
    cpu_rstrb = 1'b0;
    check("mid_rd_busy", 32'(cpu_rbusy), 32'h1);
    #2 rstN = 1'b0;
    #1 check_all_zero("rst_mid_rd");
    @(negedge clk); rstN = 1'b1;
    cpu_read(32'h0000_0010, shadow_rd(32'h0000_0010), 2, 2'b01, "post_rst_rd");

    cpu_write(32'h0040_0030, 32'hDEAD_BEEF, 4'hF, 2'b00, 10'd12, "io_wr2");
    @(negedge clk);
    check("mid_io_wr", {30'h0, io_req, cpu_wbusy}, 32'h3);
    #2 rstN = 1'b0;
    #1 check_all_zero("rst_mid_io");
    @(negedge clk); rstN = 1'b1;
    cpu_read(32'h0000_1000, shadow_rd(32'h0000_1000), 2, 2'b10, "post_rst_io");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
